display_tx_buf: RTL and testbench



---
 rtl/display_tx_buf.sv | 142 ++++++++++++++
 tb/tb_display_tx_buf.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_tx_buf.sv
// display_tx_buf: 32-entry character FIFO drained over an 8N1 UART line.
// CPU display port on one side, board TX pin on the other.
module display_tx_buf #(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       DSP_write_en,
  input  logic [6:0] DSP_data,
  input  logic       DSP_clear,
  output logic       DSP_status,
  output logic       buf_empty,
  output logic       tx_busy,
  output logic       tx
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_q;
  logic [BW-1:0] baud_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          tx_q;

  logic [5:0]    wptr_q;
  logic [5:0]    rptr_q;
  logic [6:0]    mem_q [32];

  logic          full;
  logic          empty;
  logic          wr_en;
  logic          pop;
  logic          baud_tick;

  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[4:0] == rptr_q[4:0]) &&
                     (wptr_q[5] != rptr_q[5]);
  // full is judged before any same-cycle pop; clear wins over both
  assign wr_en     = DSP_write_en && !full && !DSP_clear;
  assign pop       = (state_q == IDLE) && !empty && !DSP_clear;
  assign baud_tick = (baud_cnt_q == BAUD_LAST);

  assign DSP_status = !full;
  assign buf_empty  = empty;
  assign tx_busy    = (state_q != IDLE);
  assign tx         = tx_q;

  // character storage, no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q[4:0]] <= DSP_data;
    end
  end

  // FIFO pointers: write advance, pop advance, clear snaps read to write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= 6'd0;
      rptr_q <= 6'd0;
    end else begin
      if (wr_en) begin
        wptr_q <= wptr_q + 6'd1;
      end
      if (DSP_clear) begin
        rptr_q <= wptr_q;
      end else if (pop) begin
        rptr_q <= rptr_q + 6'd1;
      end
    end
  end

  // serializer FSM; tx is registered alongside the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q    <= {1'b0, mem_q[rptr_q[4:0]]};
            baud_cnt_q <= '0;
            bit_idx_q  <= 3'd0;
            tx_q       <= 1'b0;
            state_q    <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            baud_cnt_q <= '0;
            tx_q       <= shift_q[0];
            state_q    <= DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_tick) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_tick) begin
            baud_cnt_q <= '0;
            tx_q       <= 1'b1;
            state_q    <= IDLE;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_tx_buf.sv
// tb_display_tx_buf: vectors, corner sequences and random traffic
// against a queue-based model and a line-side UART receiver.
module tb_display_tx_buf;

  localparam int C = 16;

  logic       clk;
  logic       reset;
  logic       DSP_write_en;
  logic [6:0] DSP_data;
  logic       DSP_clear;
  logic       DSP_status;
  logic       buf_empty;
  logic       tx_busy;
  logic       tx;

  display_tx_buf #(
    .CLK_FREQ (16),
    .BAUD_RATE(1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .DSP_write_en(DSP_write_en),
    .DSP_data    (DSP_data),
    .DSP_clear   (DSP_clear),
    .DSP_status  (DSP_status),
    .buf_empty   (buf_empty),
    .tx_busy     (tx_busy),
    .tx          (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // model state: queued chars, remaining busy cycles, chars on the wire
  logic [6:0] m_fifo[$];
  int         m_busy = 0;
  logic [6:0] exp_q[$];

  logic [7:0] rx_log[$];
  int         fall_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  // one clock: drive, advance model on the edge, check flags after
  task automatic step(input logic we, input logic [6:0] d,
                      input logic clr);
    bit full;
    bit pop;
    DSP_write_en = we;
    DSP_data     = d;
    DSP_clear    = clr;
    @(posedge clk);
    full = (m_fifo.size() == 32);
    pop  = (m_busy == 0) && (m_fifo.size() != 0) && !clr;
    if (pop) begin
      exp_q.push_back(m_fifo.pop_front());
      m_busy = 10 * C;
    end else if (m_busy > 0) begin
      m_busy--;
    end
    if (clr) m_fifo.delete();
    else if (we && !full) m_fifo.push_back(d);
    @(negedge clk);
    chk("flags", {29'd0, buf_empty, DSP_status, tx_busy},
        {29'd0, m_fifo.size() == 0, m_fifo.size() != 32, m_busy != 0});
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((m_fifo.size() != 0 || m_busy != 0) && n < bound) begin
      step(1'b0, 7'd0, 1'b0);
      n++;
    end
    chk("drain_done", {31'd0, n < bound}, 32'd1);
    step(1'b0, 7'd0, 1'b0);
  endtask

  // line receiver: finds start bits, samples mid-bit, checks edges
  bit         r_act = 0;
  int         r_cnt;
  logic       r_prev;
  logic [7:0] r_byte;
  int         r_k;

  always @(negedge clk) begin
    if (reset) begin
      r_act = 0;
    end else if (!r_act) begin
      if (tx === 1'b0) begin
        r_act  = 1;
        r_cnt  = 0;
        r_prev = 1'b0;
        fall_q.push_back(cyc);
      end
    end else begin
      r_cnt++;
      if (tx !== r_prev) begin
        chk("bit_edge_align", r_cnt % C, 0);
        r_prev = tx;
      end
      if (r_cnt % C == C / 2) begin
        r_k = r_cnt / C;
        if (r_k == 0) begin
          chk("start_bit", {31'd0, tx}, 32'd0);
        end else if (r_k <= 8) begin
          r_byte[r_k-1] = tx;
        end else begin
          chk("stop_bit", {31'd0, tx}, 32'd1);
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", r_byte, 32'hFFFF);
          end else begin
            chk("frame_data", r_byte, {25'd0, exp_q.pop_front()});
          end
          rx_log.push_back(r_byte);
          r_act = 0;
        end
      end
    end
  end

  typedef struct {
    logic [6:0] ch;
    logic [9:0] line;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         busy_n;
    int         base;
    int         rb;
    int         n;
    logic [9:0] ln;

    // line images: bit0 start, bits1..8 data LSB first, bit9 stop
    vecs[0] = '{ch: 7'h41, line: 10'h282};
    vecs[1] = '{ch: 7'h55, line: 10'h2AA};
    vecs[2] = '{ch: 7'h00, line: 10'h200};
    vecs[3] = '{ch: 7'h7F, line: 10'h2FE};
    vecs[4] = '{ch: 7'h2A, line: 10'h254};

    reset        = 1'b1;
    DSP_write_en = 1'b0;
    DSP_data     = 7'd0;
    DSP_clear    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_status", {31'd0, DSP_status}, 32'd1);
    chk("rst_empty", {31'd0, buf_empty}, 32'd1);
    #2 reset = 1'b0;

    // single-character frames from the table
    for (int v = 0; v < 5; v++) begin
      drain(400);
      busy_n = 0;
      ln = vecs[v].line;
      step(1'b1, vecs[v].ch, 1'b0);
      for (int c = 0; c <= 10 * C; c++) begin
        step(1'b0, 7'd0, 1'b0);
        if (c == 0) chk("tbl_latency", {31'd0, tx}, 32'd0);
        if (tx_busy) busy_n++;
        if (c < 10 * C && c % C == C / 2)
          chk($sformatf("tbl%0d_bit%0d", v, c / C),
              {31'd0, tx}, {31'd0, ln[c/C]});
      end
      chk("tbl_busy_len", busy_n, 10 * C);
    end

    // burst of two: start bits one frame plus one idle cycle apart
    drain(400);
    base = fall_q.size();
    rb = rx_log.size();
    step(1'b1, 7'h48, 1'b0);
    step(1'b1, 7'h69, 1'b0);
    drain(600);
    if (fall_q.size() >= base + 2)
      chk("burst_period", fall_q[base+1] - fall_q[base], 10 * C + 1);
    else
      chk("burst_frames", fall_q.size() - base, 2);
    chk("burst_count", rx_log.size() - rb, 2);

    // overflow: 33 writes fill the FIFO, 34th dropped
    base = fall_q.size();
    rb = rx_log.size();
    for (int i = 0; i < 33; i++) step(1'b1, 7'(i), 1'b0);
    chk("ovf_full", {31'd0, DSP_status}, 32'd0);
    step(1'b1, 7'h7F, 1'b0);
    chk("ovf_still_full", {31'd0, DSP_status}, 32'd0);
    n = 0;
    while (!DSP_status && n < 400) begin
      step(1'b0, 7'd0, 1'b0);
      n++;
    end
    chk("ovf_status_wait", {31'd0, n < 400}, 32'd1);
    if (fall_q.size() > base)
      chk("ovf_status_rise", cyc - fall_q[base], 10 * C + 1);
    drain(40 * (10 * C + 1));
    chk("ovf_count", rx_log.size() - rb, 33);
    for (int i = 0; i < 33 && rb + i < rx_log.size(); i++)
      chk($sformatf("ovf_char%0d", i), rx_log[rb+i], i);

    // write on the pop cycle: full drops it, 31 keeps 31
    for (int i = 0; i < 33; i++) step(1'b1, 7'(8'h40 + i), 1'b0);
    chk("sim_full", {31'd0, DSP_status}, 32'd0);
    n = 0;
    while (m_busy != 0 && n < 400) begin
      step(1'b0, 7'd0, 1'b0);
      n++;
    end
    chk("sim_wait1", {31'd0, n < 400}, 32'd1);
    step(1'b1, 7'h11, 1'b0);
    chk("sim_full_drop", {31'd0, DSP_status}, 32'd1);
    n = 0;
    while (m_busy != 0 && n < 400) begin
      step(1'b0, 7'd0, 1'b0);
      n++;
    end
    chk("sim_wait2", {31'd0, n < 400}, 32'd1);
    step(1'b1, 7'h22, 1'b0);
    chk("sim_31_keep", {31'd0, DSP_status}, 32'd1);
    step(1'b1, 7'h33, 1'b0);
    chk("sim_31_plus1", {31'd0, DSP_status}, 32'd0);
    step(1'b0, 7'd0, 1'b1);
    drain(400);

    // clear during DATA of the first of five
    rb = rx_log.size();
    for (int i = 0; i < 5; i++) step(1'b1, 7'(8'h31 + i), 1'b0);
    for (int i = 0; i < 30; i++) step(1'b0, 7'd0, 1'b0);
    step(1'b0, 7'd0, 1'b1);
    chk("clr_empty", {31'd0, buf_empty}, 32'd1);
    for (int i = 0; i < 2 * (10 * C + 1); i++) step(1'b0, 7'd0, 1'b0);
    chk("clr_frames", rx_log.size() - rb, 1);
    if (rx_log.size() > rb) chk("clr_char", rx_log[rb], 32'h31);
    chk("clr_idle", {31'd0, tx_busy}, 32'd0);

    // reset during data bit 3, then a clean frame
    drain(400);
    step(1'b1, 7'h55, 1'b0);
    for (int i = 0; i <= 70; i++) step(1'b0, 7'd0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("mrst_tx", {31'd0, tx}, 32'd1);
    chk("mrst_busy", {31'd0, tx_busy}, 32'd0);
    chk("mrst_empty", {31'd0, buf_empty}, 32'd1);
    m_fifo.delete();
    exp_q.delete();
    m_busy = 0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    rb = rx_log.size();
    step(1'b1, 7'h55, 1'b0);
    drain(400);
    chk("mrst_frames", rx_log.size() - rb, 1);
    if (rx_log.size() > rb) chk("mrst_char", rx_log[rb], 32'h55);

    // random writes and occasional clears
    for (int i = 0; i < 800; i++) begin
      int r;
      r = $urandom_range(0, 99);
      step(r >= 2 && r < 40, 7'($urandom_range(0, 127)), r < 2);
    end
    drain(40 * (10 * C + 1));
    chk("all_frames_seen", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
